// File: rtl/nts_pkg.sv
// Shared NTS constants: read opcodes, protocol numbers, and the header
// buffer type with its byte-extraction helper.
package nts_pkg;

  localparam logic [3:0]  OPCODE_GET_OFFSET_UDP_DATA = 4'h0;
  localparam logic [3:0]  OPCODE_GET_LENGTH_UDP      = 4'h1;
  localparam logic [15:0] ETHERTYPE_IPV4             = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP               = 8'd17;

  localparam int HDR_WORDS = 10;

  typedef logic [HDR_WORDS-1:0][63:0] hdr_t;

  // Big-endian byte fetch: frame byte idx lives in word idx/8, byte 0 at bits 63:56.
  function automatic logic [7:0] hdr_byte(input hdr_t hdr, input logic [6:0] idx);
    logic [63:0] word;
    word = '0;
    if (idx[6:3] < 4'(HDR_WORDS))
      word = hdr[idx[6:3]] << {idx[2:0], 3'b000};
    return word[63:56];
  endfunction

endpackage

// File: rtl/nts_ip_decoder.sv
// Snoops a streamed frame, keeps its first ten words and decodes the
// Ethernet/IPv4/UDP header once the frame ends; fields served by opcode.
module nts_ip_decoder
  import nts_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic        i_clear,
  input  logic        i_process,
  input  logic [7:0]  i_last_word_data_valid,
  input  logic [63:0] i_data,
  input  logic [3:0]  i_read_opcode,
  output logic        o_detect_ipv4,
  output logic        o_detect_ipv4_bad,
  output logic [31:0] o_read_data
);

  localparam int BW = ADDR_WIDTH + 3;

  hdr_t                  hdr;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [7:0]            mask_q;
  logic                  in_frame;
  logic                  ignore;
  logic [BW-1:0]         udp_data_offset;
  logic [15:0]           udp_length;

  // A cleared frame stays ignored until i_process drops, so its tail never
  // looks like a fresh frame start.
  logic active, start, decode;
  assign active = i_process && !ignore;
  assign start  = active && !in_frame;
  assign decode = in_frame && !i_process;

  logic [15:0]   ethertype;
  logic [7:0]    ver_ihl;
  logic [3:0]    version, ihl;
  logic [7:0]    proto;
  logic [6:0]    udp_len_idx;
  logic [15:0]   udp_len_d;
  logic [BW-1:0] udp_off_d;
  logic [BW-1:0] frame_len;
  logic          is_ipv4, header_ok;

  assign ethertype   = {hdr_byte(hdr, 7'd12), hdr_byte(hdr, 7'd13)};
  assign ver_ihl     = hdr_byte(hdr, 7'd14);
  assign version     = ver_ihl[7:4];
  assign ihl         = ver_ihl[3:0];
  assign proto       = hdr_byte(hdr, 7'd23);
  assign udp_len_idx = 7'd18 + {1'b0, ihl, 2'b00};
  assign udp_len_d   = {hdr_byte(hdr, udp_len_idx), hdr_byte(hdr, udp_len_idx + 7'd1)};
  assign udp_off_d   = BW'(22) + BW'({ihl, 2'b00});
  // word_cnt still holds the frame's word count in the decode cycle.
  assign frame_len   = {word_cnt - ADDR_WIDTH'(1), 3'b000} + BW'($countones(mask_q));

  assign is_ipv4   = (ethertype == ETHERTYPE_IPV4);
  assign header_ok = (version == 4'd4) && (ihl >= 4'd5) && (proto == IP_PROTO_UDP)
                     && (frame_len >= udp_off_d);

  // NOTE: the header buffer is a handful of flops, not RAM, so it is reset
  // along with everything else; short frames then read unreceived bytes as 0.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      hdr               <= '0;
      word_cnt          <= '0;
      mask_q            <= '0;
      in_frame          <= 1'b0;
      ignore            <= 1'b0;
      udp_data_offset   <= '0;
      udp_length        <= '0;
      o_detect_ipv4     <= 1'b0;
      o_detect_ipv4_bad <= 1'b0;
    end else if (i_clear) begin
      hdr               <= '0;
      word_cnt          <= '0;
      mask_q            <= '0;
      in_frame          <= 1'b0;
      ignore            <= i_process;
      udp_data_offset   <= '0;
      udp_length        <= '0;
      o_detect_ipv4     <= 1'b0;
      o_detect_ipv4_bad <= 1'b0;
    end else begin
      in_frame <= active;
      word_cnt <= active ? word_cnt + ADDR_WIDTH'(1) : '0;
      if (!i_process)
        ignore <= 1'b0;

      for (int i = 0; i < HDR_WORDS; i++) begin
        if (start)
          hdr[i] <= (i == 0) ? i_data : 64'h0;
        else if (active && word_cnt == ADDR_WIDTH'(i))
          hdr[i] <= i_data;
      end

      if (start) begin
        mask_q            <= i_last_word_data_valid;
        udp_data_offset   <= '0;
        udp_length        <= '0;
        o_detect_ipv4     <= 1'b0;
        o_detect_ipv4_bad <= 1'b0;
      end else if (decode) begin
        udp_data_offset   <= udp_off_d;
        udp_length        <= udp_len_d;
        o_detect_ipv4     <= is_ipv4 && header_ok;
        o_detect_ipv4_bad <= is_ipv4 && !header_ok;
      end
    end
  end

  // NOTE: default assignment first so every opcode path is covered and no
  // latch is inferred.
  always_comb begin
    o_read_data = '0;
    case (i_read_opcode)
      OPCODE_GET_OFFSET_UDP_DATA: o_read_data = 32'(udp_data_offset);
      OPCODE_GET_LENGTH_UDP:      o_read_data = {16'h0, udp_length};
      default:                    o_read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_nts_ip_decoder.sv
// Directed bench for nts_ip_decoder: a table of frames with hand-computed
// flags and fields, plus reset, clear-abort and opcode sequences.
module tb_nts_ip_decoder;

  logic        i_clk = 1'b0;
  logic        i_areset = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_process = 1'b0;
  logic [7:0]  i_last_word_data_valid = 8'hFF;
  logic [63:0] i_data = '0;
  logic [3:0]  i_read_opcode = 4'h0;
  logic        o_detect_ipv4;
  logic        o_detect_ipv4_bad;
  logic [31:0] o_read_data;

  int checks = 0;
  int errors = 0;

  nts_ip_decoder #(.ADDR_WIDTH(10)) dut (
    .i_clk                  (i_clk),
    .i_areset               (i_areset),
    .i_clear                (i_clear),
    .i_process              (i_process),
    .i_last_word_data_valid (i_last_word_data_valid),
    .i_data                 (i_data),
    .i_read_opcode          (i_read_opcode),
    .o_detect_ipv4          (o_detect_ipv4),
    .o_detect_ipv4_bad      (o_detect_ipv4_bad),
    .o_read_data            (o_read_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [15:0] eth;
    logic [7:0]  vihl;
    logic [7:0]  proto;
    logic [15:0] ulen;
    int          nwords;
    logic [7:0]  mask;
    logic        exp_v4;
    logic        exp_bad;
    logic        chk_fields;
    logic [31:0] exp_off;
    logic [31:0] exp_len;
  } vec_t;

  vec_t vecs[10];
  logic [7:0] fb [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic build_frame(input vec_t v);
    int u;
    for (int i = 0; i < 128; i++) fb[i] = 8'(i * 7 + 3);
    for (int i = 12; i < 80; i++) fb[i] = 8'h00;
    fb[12] = v.eth[15:8];
    fb[13] = v.eth[7:0];
    fb[14] = v.vihl;
    fb[23] = v.proto;
    u = 14 + 4 * int'(v.vihl[3:0]);
    fb[u+4] = v.ulen[15:8];
    fb[u+5] = v.ulen[7:0];
  endtask

  function automatic logic [63:0] frame_word(input int w);
    logic [63:0] d;
    d = '0;
    for (int b = 0; b < 8; b++) d = {d[55:0], fb[8*w + b]};
    return d;
  endfunction

  // Streams the current frame buffer; flags must read 0 once the frame started.
  task automatic stream_words(input int nwords, input logic [7:0] mask, input string name);
    for (int w = 0; w < nwords; w++) begin
      @(negedge i_clk);
      if (w == 1) begin
        check({name, " mid-frame v4"}, {31'h0, o_detect_ipv4}, 32'h0);
        check({name, " mid-frame bad"}, {31'h0, o_detect_ipv4_bad}, 32'h0);
      end
      i_process = 1'b1;
      i_last_word_data_valid = mask;
      i_data = frame_word(w);
    end
  endtask

  task automatic run_vec(input vec_t v);
    build_frame(v);
    stream_words(v.nwords, v.mask, v.name);
    @(negedge i_clk);
    i_process = 1'b0;
    i_data = '0;
    check({v.name, " early v4"}, {31'h0, o_detect_ipv4}, 32'h0);
    @(negedge i_clk);
    check({v.name, " v4"}, {31'h0, o_detect_ipv4}, {31'h0, v.exp_v4});
    check({v.name, " bad"}, {31'h0, o_detect_ipv4_bad}, {31'h0, v.exp_bad});
    if (v.chk_fields) begin
      i_read_opcode = 4'h0;
      #1 check({v.name, " offset"}, o_read_data, v.exp_off);
      @(negedge i_clk);
      i_read_opcode = 4'h1;
      #1 check({v.name, " udp_len"}, o_read_data, v.exp_len);
    end
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //         name      eth       vihl   proto  ulen      nw  mask   v4    bad   fld   off    len
    vecs[0] = '{"ihl5",  16'h0800, 8'h45, 8'd17, 16'h0048, 10, 8'hFF, 1'b1, 1'b0, 1'b1, 32'd42, 32'h48};
    vecs[1] = '{"ihl6",  16'h0800, 8'h46, 8'd17, 16'h0050, 10, 8'hFF, 1'b1, 1'b0, 1'b1, 32'd46, 32'h50};
    vecs[2] = '{"ipv6",  16'h86DD, 8'h60, 8'd17, 16'h0000, 10, 8'hFF, 1'b0, 1'b0, 1'b0, 32'd0,  32'h0};
    vecs[3] = '{"tcp",   16'h0800, 8'h45, 8'd6,  16'h0048, 10, 8'hFF, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0};
    vecs[4] = '{"short", 16'h0800, 8'h45, 8'd17, 16'h0048, 4,  8'hFF, 1'b0, 1'b1, 1'b1, 32'd42, 32'h0};
    vecs[5] = '{"len42", 16'h0800, 8'h45, 8'd17, 16'h0030, 6,  8'h03, 1'b1, 1'b0, 1'b1, 32'd42, 32'h30};
    vecs[6] = '{"len41", 16'h0800, 8'h45, 8'd17, 16'h0030, 6,  8'h01, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0};
    vecs[7] = '{"ihl4",  16'h0800, 8'h44, 8'd17, 16'h0048, 10, 8'hFF, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0};
    vecs[8] = '{"ver6",  16'h0800, 8'h65, 8'd17, 16'h0048, 10, 8'hFF, 1'b0, 1'b1, 1'b0, 32'd0,  32'h0};
    vecs[9] = '{"ihl15", 16'h0800, 8'h4F, 8'd17, 16'h1234, 12, 8'h0F, 1'b1, 1'b0, 1'b1, 32'd82, 32'h1234};

    // Reset state
    repeat (3) @(negedge i_clk);
    i_areset = 1'b0;
    @(negedge i_clk);
    check("reset v4", {31'h0, o_detect_ipv4}, 32'h0);
    check("reset bad", {31'h0, o_detect_ipv4_bad}, 32'h0);
    i_read_opcode = 4'h0;
    #1 check("reset offset", o_read_data, 32'h0);
    i_read_opcode = 4'h1;
    #1 check("reset udp_len", o_read_data, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Unknown opcode after a valid frame
    run_vec(vecs[0]);
    i_read_opcode = 4'hF;
    #1 check("opcode F", o_read_data, 32'h0);
    i_read_opcode = 4'h2;
    #1 check("opcode 2", o_read_data, 32'h0);

    // Clear mid-frame: the remainder, even a complete valid frame, is ignored
    build_frame(vecs[1]);
    stream_words(3, 8'hFF, "abort");
    @(negedge i_clk);
    i_clear = 1'b1;
    i_data = frame_word(3);
    @(negedge i_clk);
    i_clear = 1'b0;
    check("clear v4", {31'h0, o_detect_ipv4}, 32'h0);
    check("clear bad", {31'h0, o_detect_ipv4_bad}, 32'h0);
    i_read_opcode = 4'h0;
    #1 check("clear offset", o_read_data, 32'h0);
    i_read_opcode = 4'h1;
    #1 check("clear udp_len", o_read_data, 32'h0);
    build_frame(vecs[0]);
    for (int w = 0; w < 10; w++) begin
      i_data = frame_word(w);
      @(negedge i_clk);
    end
    i_process = 1'b0;
    i_data = '0;
    repeat (3) @(negedge i_clk);
    check("ignored tail v4", {31'h0, o_detect_ipv4}, 32'h0);
    check("ignored tail bad", {31'h0, o_detect_ipv4_bad}, 32'h0);
    i_read_opcode = 4'h1;
    #1 check("ignored tail udp_len", o_read_data, 32'h0);
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nts_ip_decoder.md
# nts_ip_decoder

Ethernet/IPv4/UDP header decoder for the NTS parser. It snoops the received frame as it is streamed in as 64-bit words, one word per cycle. After the frame ends it reports whether the frame is IPv4 and whether that IPv4/UDP header is malformed. It also answers field queries from `nts_parser_ctrl` through a one-opcode-per-cycle read port.

## Interface
- `ADDR_WIDTH`, default 10: log2 of the frame buffer depth in 64-bit words. Byte addresses are `ADDR_WIDTH+3` bits.
- `i_clk` in 1: clock.
- `i_areset` in 1: reset, asynchronous, active-high.
- `i_clear` in 1: synchronous clear. Same effect as reset.
- `i_process` in 1: high for each cycle that `i_data` carries a frame word.
- `i_last_word_data_valid` in 8: byte-valid mask of the last word (0x01…0xFF, contiguous from bit 0). Sampled on the first `i_process` cycle.
- `i_data` in 64: frame word. Byte 0 of the word is bits 63:56 (big-endian).
- `i_read_opcode` in 4: field selector.
- `o_detect_ipv4` out 1: frame is IPv4 and well formed.
- `o_detect_ipv4_bad` out 1: frame has ethertype IPv4 but fails a check.
- `o_read_data` out 32: selected field, zero-extended.

## Operation
- Word counter (`ADDR_WIDTH` bits, wraps):
  - cleared when `i_process` is low;
  - increments on each `i_process` cycle.
- Header capture: while `i_process`=1 and word index < 10, store `i_data` into header word[index]. Words 10 and above are ignored.
- Frame length in bytes = (words−1)·8 + popcount(mask).
- Decode is performed once, on the first cycle with `i_process`=0 after a frame. Byte offsets are from frame start:
  - ethertype = bytes 12–13;
  - version = byte 14[7:4], IHL = byte 14[3:0];
  - protocol = byte 23;
  - UDP header starts at U = 14 + 4·IHL;
  - UDP length = bytes U+4..U+5.
- `o_detect_ipv4`=1 when all of the following hold:
  - ethertype=0x0800;
  - version=4;
  - IHL≥5;
  - protocol=17;
  - frame length ≥ U+8.
- `o_detect_ipv4_bad`=1 when ethertype=0x0800 and any other check fails. Non-IPv4 ethertype gives both flags 0.
- Registered fields:
  - udp_data_offset = U+8 = 22 + 4·IHL, `ADDR_WIDTH+3` bits;
  - udp_length = 16 bits.
- Opcodes, with `o_read_data` combinational from `i_read_opcode` and the registered fields:
  - 0x0 GET_OFFSET_UDP_DATA → udp_data_offset;
  - 0x1 GET_LENGTH_UDP → {16'h0, udp_length};
  - any other → 0.
- Flags and fields hold until the next `i_process` rising edge, `i_clear` or reset.
- Masks that are not contiguous are not validated here; the controller rejects them.

## Timing
- Reset and `i_clear`: all outputs 0, all fields 0, counter 0, header buffer 0.
- Result latency: flags and fields are valid from the 2nd cycle after the last `i_process` cycle. The controller reads opcode 0 in that cycle and opcode 1 in the next.
- A query has zero-cycle latency: a new opcode is reflected in `o_read_data` in the same cycle.
- Rising edge of `i_process` clears flags and fields in that cycle.
- `i_clear` mid-frame aborts capture. The remaining words of that frame are ignored until `i_process` falls and rises again.
- `i_clear` and `i_process` in the same cycle: `i_clear` wins.
- Frame shorter than 10 words: header bytes not received read as 0, and the length check then flags it bad.

## Structure
- Shared package `nts_pkg` holds:
  - opcode constants `OPCODE_GET_OFFSET_UDP_DATA`=4'h0 and `OPCODE_GET_LENGTH_UDP`=4'h1;
  - `ETHERTYPE_IPV4`=16'h0800;
  - `IP_PROTO_UDP`=8'd17.
- Single module. No sub-module is needed. Byte extraction at a variable offset is a function over the 10-word header buffer.

## Test plan
- IPv4/UDP frame, IHL=5, UDP length 0x0048, 10 words, mask 0xFF → `o_detect_ipv4`=1, bad=0; opcode 0 → 42; opcode 1 → 0x48.
- IHL=6, one options word, UDP length 0x0050 → opcode 0 → 46; opcode 1 → 0x50.
- Ethertype 0x86DD → both flags 0.
- IPv4 with protocol 6 → `o_detect_ipv4`=0, `o_detect_ipv4_bad`=1. Separately, a 4-word frame → bad=1.
- `i_clear` asserted mid-frame, then a valid frame → all outputs 0 after clear, then correct results for the second frame.
- Opcode 0xF after a valid frame → `o_read_data`=0.
